// File: rtl/intr_ctrl_if.sv
// Core-facing bus of the interrupt controller: interrupt handshake plus register port.
interface intr_ctrl_if #(
    parameter int unsigned IDW = 3
);
    logic           interrupt;
    logic [IDW-1:0] intr_id;
    logic           intr_ack;
    logic           intr_eret;
    logic           reg_wen;
    logic [1:0]     reg_addr;
    logic [31:0]    reg_din;
    logic [31:0]    reg_dout;

    modport master (
        output intr_ack, intr_eret, reg_wen, reg_addr, reg_din,
        input  interrupt, intr_id, reg_dout
    );

    modport slave (
        input  intr_ack, intr_eret, reg_wen, reg_addr, reg_din,
        output interrupt, intr_id, reg_dout
    );
endinterface

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: synchronizes sources, latches rising edges as pending,
// masks and prioritizes them, and runs the ack/eret handshake with the core.
module intr_ctrl #(
    parameter int unsigned N_SRC       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDW         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    intr_ctrl_if.slave       bus
);
    localparam int unsigned DW = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    state_t                                state_q, state_d;
    logic [SYNC_STAGES-1:0][N_SRC-1:0]     sync_q;
    logic [N_SRC-1:0]                      hist_q;
    logic [N_SRC-1:0]                      edge_q;
    logic [N_SRC-1:0]                      pending_q;
    logic [N_SRC-1:0]                      mask_q;
    logic                                  gie_q;
    logic [IDW-1:0]                        isr_id_q;
    logic [DW-1:0]                         dout_q;

    logic [N_SRC-1:0]                      eligible_c;
    logic                                  irq_c;
    logic [IDW-1:0]                        id_c;
    logic                                  ack_take_c;
    logic [N_SRC-1:0]                      clr_c;
    logic [N_SRC-1:0]                      pending_d;
    logic [DW-1:0]                         rdata_c;
    logic                                  in_service;

    assign in_service = (state_q == ST_SERVICE);
    assign eligible_c = pending_q & mask_q;
    assign irq_c      = gie_q & ~in_service & (|eligible_c);

    assign bus.interrupt = irq_c;
    assign bus.intr_id   = id_c;
    assign bus.reg_dout  = dout_q;

    // Lowest set index wins; scan from the top so the last hit is the lowest.
    always_comb begin
        id_c = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (eligible_c[i]) id_c = IDW'(i);
        end
    end

    // Handshake FSM: idle (may request) vs. in service (blocks further requests).
    always_comb begin
        state_d    = state_q;
        ack_take_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.intr_ack && irq_c) begin
                    state_d    = ST_SERVICE;
                    ack_take_c = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (bus.intr_eret) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clears from ack and W1C; a same-cycle new edge overrides the clear.
    always_comb begin
        clr_c = '0;
        if (ack_take_c) clr_c = N_SRC'(1) << id_c;
        if (bus.reg_wen && bus.reg_addr == 2'd0) clr_c = clr_c | bus.reg_din[N_SRC-1:0];
        pending_d = (pending_q & ~clr_c) | edge_q;
    end

    always_comb begin
        rdata_c = '0;
        case (bus.reg_addr)
            2'd0: rdata_c = DW'(pending_q);
            2'd1: rdata_c = DW'(mask_q);
            2'd2: begin
                rdata_c[0]       = gie_q;
                rdata_c[1]       = in_service;
                rdata_c[8 +: IDW] = isr_id_q;
            end
            2'd3: begin
                rdata_c[31]      = irq_c;
                rdata_c[IDW-1:0] = id_c;
            end
            default: rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            hist_q    <= '0;
            edge_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            isr_id_q  <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], src};
            hist_q    <= sync_q[SYNC_STAGES-1];
            edge_q    <= sync_q[SYNC_STAGES-1] & ~hist_q;
            pending_q <= pending_d;
            dout_q    <= rdata_c;
            if (ack_take_c) isr_id_q <= id_c;
            if (bus.reg_wen && bus.reg_addr == 2'd1) mask_q <= bus.reg_din[N_SRC-1:0];
            if (bus.reg_wen && bus.reg_addr == 2'd2) gie_q  <= bus.reg_din[0];
        end
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic
// compared against an event-level reference model.
module tb_intr_ctrl;
    localparam int unsigned N   = 8;
    localparam int unsigned LAT = 3;   // src sample to pending set, in edges

    logic         clk;
    logic         rst;
    logic [N-1:0] src;
    int           n_checks;
    int           n_pass;

    intr_ctrl_if #(.IDW(3)) bus ();

    intr_ctrl #(.N_SRC(8), .SYNC_STAGES(2), .IDW(3)) dut (
        .clk (clk),
        .rst (rst),
        .src (src),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [N-1:0]  m_pend, m_mask;
    logic          m_gie, m_insvc;
    logic [2:0]    m_isr;
    logic [31:0]   m_dout;
    logic [N-1:0]  m_samp [0:LAT];   // m_samp[j] = src sampled j+1 edges ago

    function automatic logic m_irq();
        return m_gie && !m_insvc && ((m_pend & m_mask) != '0);
    endfunction

    function automatic logic [2:0] m_id();
        logic [N-1:0] e;
        logic [2:0]   r;
        e = m_pend & m_mask;
        r = 3'd0;
        for (int i = N - 1; i >= 0; i--) if (e[i]) r = 3'(i);
        return r;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_gie = 1'b0; m_insvc = 1'b0; m_isr = '0; m_dout = '0;
        for (int j = 0; j <= LAT; j++) m_samp[j] = '0;
    endtask

    // Advance one clock: update the model from the inputs as seen at this edge.
    task automatic cycle();
        logic [N-1:0] ev, clr;
        logic         irq;
        logic [2:0]   id;
        logic [31:0]  rd;
        irq = m_irq();
        id  = m_id();
        case (bus.reg_addr)
            2'd0:    rd = {24'h0, m_pend};
            2'd1:    rd = {24'h0, m_mask};
            2'd2:    rd = {21'h0, m_isr, 6'h0, m_insvc, m_gie};
            default: rd = {irq, 28'h0, id};
        endcase
        ev  = m_samp[LAT-1] & ~m_samp[LAT];
        clr = '0;
        if (bus.intr_ack && irq) begin
            clr[id] = 1'b1; m_insvc = 1'b1; m_isr = id;
        end else if (bus.intr_eret && m_insvc) begin
            m_insvc = 1'b0;
        end
        if (bus.reg_wen) begin
            case (bus.reg_addr)
                2'd0:    clr = clr | bus.reg_din[N-1:0];
                2'd1:    m_mask = bus.reg_din[N-1:0];
                2'd2:    m_gie = bus.reg_din[0];
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | ev;
        for (int j = LAT; j > 0; j--) m_samp[j] = m_samp[j-1];
        m_samp[0] = src;
        m_dout = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.reg_wen = 1'b1; bus.reg_addr = a; bus.reg_din = d;
        cycle();
        bus.reg_wen = 1'b0; bus.reg_din = '0;
    endtask

    task automatic ack_eret();
        bus.intr_ack = 1'b1; cycle(); bus.intr_ack = 1'b0;
        bus.intr_eret = 1'b1; cycle(); bus.intr_eret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; src = '0;
        bus.intr_ack = 1'b0; bus.intr_eret = 1'b0; bus.reg_wen = 1'b0;
        bus.reg_addr = 2'd0; bus.reg_din = '0;
        #2;
        n_checks++; if (bus.interrupt !== 1'b0) $display("FAIL rst_irq got %0b want 0", bus.interrupt); else n_pass++;
        n_checks++; if (bus.intr_id !== 3'd0) $display("FAIL rst_id got %0d want 0", bus.intr_id); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.reg_dout !== 32'h0) $display("FAIL rst_dout got %h want 0", bus.reg_dout); else n_pass++;
        model_reset();
        rst = 1'b0;
        bus.reg_addr = 2'd2;
        cycle();
        n_checks++; if (bus.reg_dout !== 32'h0) $display("FAIL rst_status got %h want 0", bus.reg_dout); else n_pass++;
    endtask

    task automatic test_latency();
        wr(2'd1, 32'hFF);
        wr(2'd2, 32'h1);
        bus.reg_addr = 2'd0;
        src[3] = 1'b1;
        cycle(); cycle(); src[3] = 1'b0; cycle();
        n_checks++; if (bus.interrupt !== 1'b0) $display("FAIL lat_early irq got %0b want 0", bus.interrupt); else n_pass++;
        cycle();
        n_checks++; if (bus.interrupt !== 1'b1) $display("FAIL lat_irq got %0b want 1", bus.interrupt); else n_pass++;
        n_checks++; if (bus.intr_id !== 3'd3) $display("FAIL lat_id got %0d want 3", bus.intr_id); else n_pass++;
        cycle();
        n_checks++; if (bus.reg_dout !== 32'h08) $display("FAIL lat_pending got %h want 08", bus.reg_dout); else n_pass++;
        ack_eret();
    endtask

    task automatic test_priority();
        src = 8'h24;
        cycle(); src = '0; cycle(); cycle(); cycle();
        n_checks++; if (bus.intr_id !== 3'd2) $display("FAIL prio_id got %0d want 2", bus.intr_id); else n_pass++;
        bus.intr_ack = 1'b1; bus.reg_addr = 2'd2;
        cycle();
        bus.intr_ack = 1'b0;
        n_checks++; if (bus.interrupt !== 1'b0) $display("FAIL prio_ack_irq got %0b want 0", bus.interrupt); else n_pass++;
        cycle();
        n_checks++; if (bus.reg_dout !== 32'h203) $display("FAIL prio_status got %h want 203", bus.reg_dout); else n_pass++;
        bus.reg_addr = 2'd0;
        cycle();
        n_checks++; if (bus.reg_dout !== 32'h20) $display("FAIL prio_pending got %h want 20", bus.reg_dout); else n_pass++;
        bus.intr_eret = 1'b1; cycle(); bus.intr_eret = 1'b0;
        n_checks++; if (bus.interrupt !== 1'b1) $display("FAIL prio_eret_irq got %0b want 1", bus.interrupt); else n_pass++;
        n_checks++; if (bus.intr_id !== 3'd5) $display("FAIL prio_eret_id got %0d want 5", bus.intr_id); else n_pass++;
        ack_eret();
    endtask

    task automatic test_w1c_race();
        src[1] = 1'b1;
        cycle(); src[1] = 1'b0; cycle(); cycle();
        wr(2'd0, 32'h02);   // W1C lands on the same edge that sets pending[1]
        n_checks++; if (bus.interrupt !== 1'b1 || bus.intr_id !== 3'd1)
            $display("FAIL w1c_race irq/id got %0b/%0d want 1/1", bus.interrupt, bus.intr_id); else n_pass++;
        bus.reg_addr = 2'd0;
        cycle();
        n_checks++; if (bus.reg_dout !== 32'h02) $display("FAIL w1c_pending got %h want 02", bus.reg_dout); else n_pass++;
        ack_eret();
    endtask

    task automatic test_mask();
        wr(2'd1, 32'h00);
        src[0] = 1'b1;
        cycle(); src[0] = 1'b0; cycle(); cycle(); cycle();
        bus.reg_addr = 2'd0;
        cycle();
        n_checks++; if (bus.interrupt !== 1'b0) $display("FAIL mask_irq got %0b want 0", bus.interrupt); else n_pass++;
        cycle();
        n_checks++; if (bus.reg_dout !== 32'h01) $display("FAIL mask_pending got %h want 01", bus.reg_dout); else n_pass++;
        wr(2'd1, 32'h01);
        n_checks++; if (bus.interrupt !== 1'b1 || bus.intr_id !== 3'd0)
            $display("FAIL mask_enable irq/id got %0b/%0d want 1/0", bus.interrupt, bus.intr_id); else n_pass++;
        ack_eret();
        wr(2'd1, 32'hFF);
    endtask

    task automatic test_ignored();
        bus.reg_addr = 2'd2;
        bus.intr_ack = 1'b1; cycle(); bus.intr_ack = 1'b0;
        bus.intr_eret = 1'b1; cycle(); bus.intr_eret = 1'b0;
        cycle();
        n_checks++; if (bus.reg_dout !== 32'h001) $display("FAIL ignore_status got %h want 001", bus.reg_dout); else n_pass++;
        src[4] = 1'b1;
        repeat (4) cycle();
        n_checks++; if (bus.interrupt !== 1'b1 || bus.intr_id !== 3'd4)
            $display("FAIL held_irq irq/id got %0b/%0d want 1/4", bus.interrupt, bus.intr_id); else n_pass++;
        ack_eret();
        bus.reg_addr = 2'd0;
        repeat (10) cycle();
        n_checks++; if (bus.interrupt !== 1'b0) $display("FAIL held_rearm irq got %0b want 0", bus.interrupt); else n_pass++;
        n_checks++; if (bus.reg_dout !== 32'h0) $display("FAIL held_pending got %h want 0", bus.reg_dout); else n_pass++;
        src[4] = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            src           = N'($urandom);
            bus.intr_ack  = ($urandom_range(0, 3) == 0);
            bus.intr_eret = ($urandom_range(0, 3) == 0);
            bus.reg_wen   = ($urandom_range(0, 7) == 0);
            bus.reg_addr  = 2'($urandom_range(0, 3));
            bus.reg_din   = $urandom;
            if (bus.reg_wen && bus.reg_addr == 2'd2) bus.reg_din[0] = ($urandom_range(0, 3) != 0);
            cycle();
            n_checks++; if (bus.interrupt !== m_irq()) $display("FAIL rnd_irq n=%0d got %0b want %0b", n, bus.interrupt, m_irq()); else n_pass++;
            n_checks++; if (bus.intr_id !== m_id()) $display("FAIL rnd_id n=%0d got %0d want %0d", n, bus.intr_id, m_id()); else n_pass++;
            n_checks++; if (bus.reg_dout !== m_dout) $display("FAIL rnd_dout n=%0d got %h want %h", n, bus.reg_dout, m_dout); else n_pass++;
        end
        src = '0; bus.intr_ack = 1'b0; bus.intr_eret = 1'b0; bus.reg_wen = 1'b0; bus.reg_din = '0;
        repeat (5) cycle();
    endtask

    task automatic test_reset_mid();
        wr(2'd1, 32'hFF);
        wr(2'd2, 32'h1);
        if (m_insvc) begin bus.intr_eret = 1'b1; cycle(); bus.intr_eret = 1'b0; end
        wr(2'd0, 32'hFF);
        src = 8'h0F;
        cycle(); src = '0; cycle(); cycle(); cycle();
        bus.intr_ack = 1'b1; cycle(); bus.intr_ack = 1'b0;   // takes id 0, pending 0x0E
        src = 8'h01;
        cycle(); src = '0; cycle(); cycle(); cycle();
        bus.reg_addr = 2'd0;
        cycle(); cycle();
        n_checks++; if (bus.reg_dout !== 32'h0F) $display("FAIL mid_pending got %h want 0F", bus.reg_dout); else n_pass++;
        bus.reg_addr = 2'd2;
        cycle();
        n_checks++; if (bus.reg_dout !== 32'h003) $display("FAIL mid_status got %h want 003", bus.reg_dout); else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_checks++; if (bus.interrupt !== 1'b0 || bus.intr_id !== 3'd0 || bus.reg_dout !== 32'h0)
            $display("FAIL mid_async irq/id/dout got %0b/%0d/%h want 0/0/0", bus.interrupt, bus.intr_id, bus.reg_dout); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int a = 0; a < 4; a++) begin
            bus.reg_addr = 2'(a);
            cycle();
            n_checks++; if (bus.reg_dout !== 32'h0) $display("FAIL mid_reg%0d got %h want 0", a, bus.reg_dout); else n_pass++;
        end
        n_checks++; if (bus.interrupt !== 1'b0) $display("FAIL mid_irq_after got %0b want 0", bus.interrupt); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_latency();
        test_priority();
        test_w1c_race();
        test_mask();
        test_ignored();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
